// File: rtl/tensor_pkg.sv
// tensor_pkg
// Shared types and constants for the 8x8x3 tensor loader/builder/reader path.
//   TENSOR_* : tensor geometry and total sample count
//   *_W      : address field widths
//   loader_state_t : loader FSM states
package tensor_pkg;

  localparam int TENSOR_ROWS    = 8;
  localparam int TENSOR_COLS    = 8;
  localparam int TENSOR_CHANS   = 3;
  localparam int TENSOR_SAMPLES = TENSOR_ROWS * TENSOR_COLS * TENSOR_CHANS;

  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int CHA_W = 2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    FULL  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/tensor_addr_counter.sv
// tensor_addr_counter
// Cascaded channel/column/row position counter walking an HWC tensor in
// row-major, channel-innermost order.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   inc          : advance one position (wraps from the last index to 0)
//   clr          : return to position 0 (takes priority over inc)
//   row/col/cha  : current position
//   last         : current position is the final index of the tensor
module tensor_addr_counter
  import tensor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [CHA_W-1:0] cha,
  output logic             last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CHA_W-1:0] cha_q, cha_d;

  logic cha_wrap, col_wrap, row_wrap;

  assign cha_wrap = (cha_q == CHA_W'(TENSOR_CHANS - 1));
  assign col_wrap = (col_q == COL_W'(TENSOR_COLS - 1));
  assign row_wrap = (row_q == ROW_W'(TENSOR_ROWS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    cha_d = cha_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      cha_d = '0;
    end else if (inc) begin
      // Each field only moves when every faster field below it wraps.
      cha_d = cha_wrap ? '0 : cha_q + 1'b1;
      if (cha_wrap) begin
        col_d = col_wrap ? '0 : col_q + 1'b1;
        if (col_wrap) begin
          row_d = row_wrap ? '0 : row_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
      cha_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      cha_q <= cha_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign cha  = cha_q;
  assign last = row_wrap && col_wrap && cha_wrap;

endmodule

// File: rtl/tensor_loader.sv
// tensor_loader
// Turns a valid/ready HWC sample stream into one addressed write per
// accepted sample for the 8x8x3 tensor builder, then holds off input until
// the consumer acknowledges the completed tensor.
// Optional feature: define TENSOR_LOADER_FRAME_CHECK_EN to honour s_last and
// drive the sticky err flag; otherwise s_last is ignored and err is 0.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  : input sample stream
//   s_last                  : end-of-tensor marker (frame check only)
//   row/col/cha_addr        : registered write address
//   data_out, wr_en         : registered write data and one-cycle write strobe
//   tensor_valid            : tensor fully written, waiting for tensor_ack
//   tensor_ack              : consumer releases the loader
//   err                     : sticky framing error
module tensor_loader
  import tensor_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic [ROW_W-1:0]        row_addr,
  output logic [COL_W-1:0]        col_addr,
  output logic [CHA_W-1:0]        cha_addr,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    wr_en,
  output logic                    tensor_valid,
  input  logic                    tensor_ack,
  output logic                    err
);

  loader_state_t state_q, state_d;

  logic [ROW_W-1:0]        row_addr_q, row_addr_d;
  logic [COL_W-1:0]        col_addr_q, col_addr_d;
  logic [CHA_W-1:0]        cha_addr_q, cha_addr_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    wr_en_q, wr_en_d;

  logic [ROW_W-1:0] cnt_row;
  logic [COL_W-1:0] cnt_col;
  logic [CHA_W-1:0] cnt_cha;
  logic             cnt_last;
  logic             accept;
  logic             resync;

  assign s_ready = (state_q == LOAD);
  assign accept  = s_valid && s_ready;

  // The counter wraps to 0 by itself after the final index, so clr is only
  // needed for an early s_last resync.
  tensor_addr_counter u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .clr  (resync),
    .row  (cnt_row),
    .col  (cnt_col),
    .cha  (cnt_cha),
    .last (cnt_last)
  );

`ifdef TENSOR_LOADER_FRAME_CHECK_EN
  logic err_q, err_d;

  assign resync = accept && s_last && !cnt_last;

  always_comb begin
    err_d = err_q;
    if (resync || (accept && cnt_last && !s_last)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_s_last;

  assign unused_s_last = s_last;
  assign resync        = 1'b0;
  assign err           = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    row_addr_d = row_addr_q;
    col_addr_d = col_addr_q;
    cha_addr_d = cha_addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    if (accept) begin
      row_addr_d = cnt_row;
      col_addr_d = cnt_col;
      cha_addr_d = cnt_cha;
      data_d     = s_data;
      wr_en_d    = 1'b1;
    end
    case (state_q)
      LOAD:    if (accept && cnt_last) state_d = FLUSH;
      FLUSH:   state_d = FULL;
      FULL:    if (tensor_ack) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      row_addr_q <= '0;
      col_addr_q <= '0;
      cha_addr_q <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_addr_q <= row_addr_d;
      col_addr_q <= col_addr_d;
      cha_addr_q <= cha_addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign row_addr     = row_addr_q;
  assign col_addr     = col_addr_q;
  assign cha_addr     = cha_addr_q;
  assign data_out     = data_q;
  assign wr_en        = wr_en_q;
  assign tensor_valid = (state_q == FULL);

endmodule

// File: tb/tb_tensor_loader.sv
// tb_tensor_loader
// Directed self-checking bench for tensor_loader. Each test task drives its
// own scenario and compares against hand-derived HWC addresses and data.
// Frame-check scenarios follow TENSOR_LOADER_FRAME_CHECK_EN.
module tb_tensor_loader;

  localparam int WIDTH = 17;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [WIDTH-1:0]  s_data;
  logic              s_last;
  logic [2:0]        row_addr;
  logic [2:0]        col_addr;
  logic [1:0]        cha_addr;
  logic [WIDTH-1:0]  data_out;
  logic              wr_en;
  logic              tensor_valid;
  logic              tensor_ack;
  logic              err;

  int checks = 0;
  int passes = 0;

  tensor_loader #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .row_addr     (row_addr),
    .col_addr     (col_addr),
    .cha_addr     (cha_addr),
    .data_out     (data_out),
    .wr_en        (wr_en),
    .tensor_valid (tensor_valid),
    .tensor_ack   (tensor_ack),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {row, col, cha} for a linear HWC index.
  function automatic logic [7:0] addr_of(input int idx);
    logic [2:0] r;
    logic [2:0] c;
    logic [1:0] ch;
    r  = 3'(idx / 24);
    c  = 3'((idx % 24) / 3);
    ch = 2'(idx % 3);
    return {r, c, ch};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    tensor_ack = 1'b0;
    s_data     = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    tensor_ack = 1'b0;
    s_data     = '0;
    #3;
    checks++;
    if ({row_addr, col_addr, cha_addr, data_out, wr_en, tensor_valid, err} !== '0) begin
      $display("[TB] FAIL reset_outputs: got addr=%h data=%h wr=%b tv=%b err=%b, want all 0",
               {row_addr, col_addr, cha_addr}, data_out, wr_en, tensor_valid, err);
    end else passes++;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", s_ready);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 192; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(i);
      tick();
      checks++;
      if (wr_en !== 1'b1 || {row_addr, col_addr, cha_addr} !== addr_of(i) || data_out !== WIDTH'(i)) begin
        $display("[TB] FAIL b2b_write[%0d]: got wr=%b addr=%h data=%0d want wr=1 addr=%h data=%0d",
                 i, wr_en, {row_addr, col_addr, cha_addr}, data_out, addr_of(i), i);
      end else passes++;
    end
    // s_valid stays high through FLUSH and FULL; nothing may be accepted.
    checks++;
    if (tensor_valid !== 1'b0 || s_ready !== 1'b0)
      $display("[TB] FAIL b2b_flush: got tv=%b ready=%b want tv=0 ready=0", tensor_valid, s_ready);
    else passes++;
    tick();
    checks++;
    if (tensor_valid !== 1'b1 || wr_en !== 1'b0 || s_ready !== 1'b0)
      $display("[TB] FAIL b2b_full: got tv=%b wr=%b ready=%b want 1 0 0", tensor_valid, wr_en, s_ready);
    else passes++;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (tensor_valid !== 1'b1 || wr_en !== 1'b0 || s_ready !== 1'b0 ||
          {row_addr, col_addr, cha_addr} !== addr_of(191) || data_out !== WIDTH'(191))
        $display("[TB] FAIL full_hold[%0d]: got tv=%b wr=%b ready=%b addr=%h data=%0d",
                 k, tensor_valid, wr_en, s_ready, {row_addr, col_addr, cha_addr}, data_out);
      else passes++;
    end
    tensor_ack = 1'b1;
    s_data     = '0;
    tick();
    tensor_ack = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || tensor_valid !== 1'b0 || wr_en !== 1'b0)
      $display("[TB] FAIL ack_release: got ready=%b tv=%b wr=%b want 1 0 0", s_ready, tensor_valid, wr_en);
    else passes++;
    tick();
    s_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || {row_addr, col_addr, cha_addr} !== 8'h00 || data_out !== '0)
      $display("[TB] FAIL ack_first_write: got wr=%b addr=%h data=%0d want wr=1 addr=00 data=0",
               wr_en, {row_addr, col_addr, cha_addr}, data_out);
    else passes++;
  endtask

  task automatic test_gaps();
    logic [WIDTH-1:0] mem [192];
    int idx;
    int exp_wr;
    int cyc;
    int slot;
    logic vld;
    do_reset();
    for (int k = 0; k < 192; k++) mem[k] = '1;
    idx    = 0;
    exp_wr = 0;
    cyc    = 0;
    while (idx < 192 && cyc < 1000) begin
      vld     = ((cyc * 7) % 10) >= 3;
      s_valid = vld;
      s_data  = vld ? WIDTH'(idx) : '1;
      tick();
      if (wr_en === 1'b1) begin
        checks++;
        if ({row_addr, col_addr, cha_addr} !== addr_of(exp_wr))
          $display("[TB] FAIL gap_addr[%0d]: got %h want %h", exp_wr, {row_addr, col_addr, cha_addr}, addr_of(exp_wr));
        else passes++;
        slot = int'(row_addr) * 24 + int'(col_addr) * 3 + int'(cha_addr);
        if (slot < 192) mem[slot] = data_out;
        exp_wr++;
      end
      if (vld) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    checks++;
    if (exp_wr !== 192) $display("[TB] FAIL gap_wr_count: got %0d want 192", exp_wr);
    else passes++;
    for (int k = 0; k < 192; k++) begin
      checks++;
      if (mem[k] !== WIDTH'(k)) $display("[TB] FAIL gap_mem[%0d]: got %0d want %0d", k, mem[k], k);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(i + 1000);
      tick();
    end
    s_valid = 1'b0;
    rst     = 1'b0;
    #2;
    checks++;
    if ({row_addr, col_addr, cha_addr, data_out, wr_en, tensor_valid, err} !== '0)
      $display("[TB] FAIL midreset_outputs: got addr=%h data=%0d wr=%b tv=%b err=%b want all 0",
               {row_addr, col_addr, cha_addr}, data_out, wr_en, tensor_valid, err);
    else passes++;
    tick();
    rst = 1'b1;
    tick();
    s_valid = 1'b1;
    s_data  = WIDTH'(77);
    tick();
    s_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || {row_addr, col_addr, cha_addr} !== 8'h00 || data_out !== WIDTH'(77))
      $display("[TB] FAIL midreset_restart: got wr=%b addr=%h data=%0d want wr=1 addr=00 data=77",
               wr_en, {row_addr, col_addr, cha_addr}, data_out);
    else passes++;
  endtask

  task automatic test_ack_held();
    do_reset();
    tensor_ack = 1'b1;
    for (int i = 0; i < 192; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(i);
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || {row_addr, col_addr, cha_addr} !== addr_of(191) || tensor_valid !== 1'b0 || s_ready !== 1'b0)
      $display("[TB] FAIL ackheld_last: got wr=%b addr=%h tv=%b ready=%b want 1 %h 0 0",
               wr_en, {row_addr, col_addr, cha_addr}, tensor_valid, s_ready, addr_of(191));
    else passes++;
    tick();
    checks++;
    if (tensor_valid !== 1'b1 || s_ready !== 1'b0)
      $display("[TB] FAIL ackheld_full: got tv=%b ready=%b want 1 0", tensor_valid, s_ready);
    else passes++;
    tick();
    checks++;
    if (tensor_valid !== 1'b0 || s_ready !== 1'b1)
      $display("[TB] FAIL ackheld_leave: got tv=%b ready=%b want 0 1", tensor_valid, s_ready);
    else passes++;
    tensor_ack = 1'b0;
  endtask

  task automatic test_frame_check();
    do_reset();
    for (int i = 0; i <= 100; i++) begin
      s_valid = 1'b1;
      s_last  = (i == 100);
      s_data  = WIDTH'(i);
      tick();
    end
    s_last = 1'b0;
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
    checks++;
    if (err !== 1'b1 || wr_en !== 1'b1 || {row_addr, col_addr, cha_addr} !== addr_of(100) || data_out !== WIDTH'(100))
      $display("[TB] FAIL early_last: got err=%b wr=%b addr=%h data=%0d want 1 1 %h 100",
               err, wr_en, {row_addr, col_addr, cha_addr}, data_out, addr_of(100));
    else passes++;
    s_data = WIDTH'(500);
    tick();
    s_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || wr_en !== 1'b1 || {row_addr, col_addr, cha_addr} !== 8'h00 || data_out !== WIDTH'(500))
      $display("[TB] FAIL resync_write: got err=%b wr=%b addr=%h data=%0d want 1 1 00 500",
               err, wr_en, {row_addr, col_addr, cha_addr}, data_out);
    else passes++;
    do_reset();
    checks++;
    if (err !== 1'b0) $display("[TB] FAIL err_cleared: got %b want 0", err);
    else passes++;
    for (int i = 0; i < 192; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(i);
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || tensor_valid !== 1'b0)
      $display("[TB] FAIL missing_last: got err=%b tv=%b want 1 0", err, tensor_valid);
    else passes++;
    tick();
    checks++;
    if (tensor_valid !== 1'b1 || err !== 1'b1)
      $display("[TB] FAIL missing_last_full: got tv=%b err=%b want 1 1", tensor_valid, err);
    else passes++;
`else
    checks++;
    if (err !== 1'b0 || {row_addr, col_addr, cha_addr} !== addr_of(100))
      $display("[TB] FAIL last_ignored: got err=%b addr=%h want 0 %h", err, {row_addr, col_addr, cha_addr}, addr_of(100));
    else passes++;
    s_data = WIDTH'(500);
    tick();
    s_valid = 1'b0;
    checks++;
    if (err !== 1'b0 || wr_en !== 1'b1 || {row_addr, col_addr, cha_addr} !== addr_of(101))
      $display("[TB] FAIL no_resync: got err=%b wr=%b addr=%h want 0 1 %h",
               err, wr_en, {row_addr, col_addr, cha_addr}, addr_of(101));
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_mid_reset();
    test_ack_held();
    test_frame_check();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
